// File: rtl/rv32im_dmem.sv
// Data-memory responder for the rv32im load/store unit: masked word writes, full-word reads, fixed wait states.
// Optional out-of-range error reporting is enabled by defining DMEM_RANGE_CHECK_EN.
module rv32im_dmem #(
    parameter int DEPTH          = 1024,
    parameter int WAIT_CYCLES    = 0,
    parameter int API_ADDR_WIDTH = 32,
    parameter int API_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [API_ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]                wr_mask_i,
    input  logic [API_DATA_WIDTH-1:0] wdata_i,
    output logic [API_DATA_WIDTH-1:0] rdata_o,
    output logic                      ready_o,
    output logic                      err_o
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [3:0]                wait_cnt_r;
    logic [3:0]                wait_cnt_s;
    logic                      latch_s;
    logic                      access_s;
    logic                      blocked_s;
    logic [IDX_W-1:0]          idx_r;
    logic [3:0]                mask_r;
    logic [API_DATA_WIDTH-1:0] wdata_r;
    logic [API_DATA_WIDTH-1:0] stored_s;
    logic [API_DATA_WIDTH-1:0] merged_s;
    logic [API_DATA_WIDTH-1:0] rdata_r;
    logic                      ready_r;
    logic                      unused_addr_s;
    logic [API_DATA_WIDTH-1:0] mem_r [DEPTH];

    // Byte offset bits never select anything; upper bits only matter to the range check.
    assign unused_addr_s = &{1'b0, addr_i};

    // State and wait-counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state logic, request capture strobe and access strobe.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        latch_s    = 1'b0;
        access_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    latch_s    = 1'b1;
                    wait_cnt_s = WAIT_INIT;
                    if (WAIT_INIT != 4'd0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wait_cnt_s = wait_cnt_r - 4'd1;
                // "<=" rather than "==" so a corrupted zero count cannot wrap into a 16-cycle stall.
                if (wait_cnt_r <= 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                access_s = 1'b1;
                state_s  = ST_RESP;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_r   <= {IDX_W{1'b0}};
            mask_r  <= 4'b0000;
            wdata_r <= {API_DATA_WIDTH{1'b0}};
        end else if (latch_s) begin
            idx_r   <= addr_i[IDX_W+1:2];
            mask_r  <= wr_mask_i;
            wdata_r <= wdata_i;
        end else begin
            idx_r   <= idx_r;
            mask_r  <= mask_r;
            wdata_r <= wdata_r;
        end
    end

    assign stored_s = mem_r[idx_r];

    // Lane merge: the post-write word, which equals the stored word for a read.
    always_comb begin
        merged_s = stored_s;
        for (int n = 0; n < 4; n++) begin
            if (mask_r[n]) begin
                merged_s[8*n +: 8] = wdata_r[8*n +: 8];
            end else begin
                merged_s[8*n +: 8] = stored_s[8*n +: 8];
            end
        end
    end

    // Word array; deliberately outside reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (access_s && !blocked_s && (mask_r != 4'b0000)) begin
            mem_r[idx_r] <= merged_s;
        end
    end

    // Registered read data and completion pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r <= {API_DATA_WIDTH{1'b0}};
            ready_r <= 1'b0;
        end else begin
            ready_r <= access_s;
            if (access_s) begin
                rdata_r <= blocked_s ? {API_DATA_WIDTH{1'b0}} : merged_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign rdata_o = rdata_r;
    assign ready_o = ready_r;

`ifdef DMEM_RANGE_CHECK_EN
    logic range_err_s;
    logic range_err_r;
    logic err_r;

    assign range_err_s = (addr_i >> (IDX_W + 2)) != {API_ADDR_WIDTH{1'b0}};

    // Out-of-range flag travels with the captured request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_err_r <= 1'b0;
        end else if (latch_s) begin
            range_err_r <= range_err_s;
        end else begin
            range_err_r <= range_err_r;
        end
    end

    // Error is only ever raised in the RESP cycle alongside ready_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= access_s & range_err_r;
        end
    end

    assign blocked_s = range_err_r;
    assign err_o     = err_r;
`else
    assign blocked_s = 1'b0;
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rv32im_dmem.sv
// Scoreboard bench for rv32im_dmem: two instances (0 and 3 wait states) driven with directed and random requests.
// Expected responses come from a word-array reference model; a monitor per instance checks data, error and timing.
module tb_rv32im_dmem;

    localparam int DEPTH = 1024;
    localparam int W0    = 0;
    localparam int W1    = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          exp_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en    [2];
    logic [31:0] addr  [2];
    logic [3:0]  mask  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] ref_mem [2][DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rv32im_dmem #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dmem0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .addr_i(addr[0]), .wr_mask_i(mask[0]),
        .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0])
    );

    rv32im_dmem #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dmem1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .addr_i(addr[1]), .wr_mask_i(mask[1]),
        .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1])
    );

    function automatic void check32(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at cycle %0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endfunction

    // Reference: word index is the byte address / 4 modulo DEPTH; out-of-range only matters with the check enabled.
    function automatic void model(input int i, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                                  output logic [31:0] data, output logic e);
        int unsigned word_no;
        int          idx;
        logic [31:0] w;
        word_no = a / 4;
        idx     = int'(word_no % DEPTH);
        data    = 32'h0;
        e       = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        if (word_no >= DEPTH) begin
            e = 1'b1;
            return;
        end
`endif
        w = ref_mem[i][idx];
        for (int n = 0; n < 4; n++) begin
            if (m[n]) w[8*n +: 8] = d[8*n +: 8];
        end
        if (m != 4'b0000) ref_mem[i][idx] = w;
        data = w;
    endfunction

    function automatic void mon(input int i);
        exp_t e;
        int   sz;
        sz = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            check32("unexpected_ready", i, 32'd1, 32'd0);
            return;
        end
        if (i == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check32("rdata", i, rdata[i], e.data);
        check32("err", i, {31'b0, err[i]}, {31'b0, e.err});
        check32("ready_cycle", i, cyc, e.exp_cyc);
    endfunction

    always @(negedge clk) if (ready[0] === 1'b1) mon(0);
    always @(negedge clk) if (ready[1] === 1'b1) mon(1);

    // Called at a negedge with the DUT in IDLE (from_resp=0) or in RESP (from_resp=1).
    task automatic issue(input int i, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input bit from_resp);
        exp_t e;
        int   w;
        int   k;
        w        = (i == 0) ? W0 : W1;
        en[i]    = 1'b1;
        addr[i]  = a;
        mask[i]  = m;
        wdata[i] = d;
        k        = cyc + (from_resp ? 2 : 1);
        model(i, a, m, d, e.data, e.err);
        e.exp_cyc = k + 1 + w;
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Returns at the negedge inside the RESP cycle; optionally disturbs inputs once the request is captured.
    task automatic wait_ready(input int i, input bit scramble, input bit from_resp);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                seen = 1'b1;
            end else if (scramble && (n >= (from_resp ? 1 : 0))) begin
                en[i]    = 1'($urandom_range(0, 1));
                addr[i]  = $urandom;
                wdata[i] = $urandom;
                mask[i]  = 4'($urandom_range(0, 15));
            end
        end
        if (!seen) check32("ready_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic run_inst(input int i);
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        issue(i, 32'h0, 4'hF, $urandom, 1'b0);
        wait_ready(i, 1'b0, 1'b0);
        for (int w = 1; w < 16; w++) begin
            issue(i, 32'(w * 4), 4'hF, $urandom, 1'b1);
            wait_ready(i, 1'b0, 1'b1);
        end
        // Directed: full word, byte lanes, out-of-range/alias.
        issue(i, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h10, 4'h0, 32'h0,        1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h20, 4'hF, 32'h11223344, 1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h20, 4'h2, 32'h0000AA00, 1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h20, 4'h0, 32'h0,        1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h20, 4'hC, 32'hBBCC0000, 1'b1); wait_ready(i, 1'b1, 1'b1);
        issue(i, 32'h20, 4'h0, 32'h0,        1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h1000, 4'hF, 32'h77,     1'b1); wait_ready(i, 1'b0, 1'b1);
        issue(i, 32'h0,  4'h0, 32'h0,        1'b1); wait_ready(i, 1'b0, 1'b1);
        for (int n = 0; n < 50; n++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
            m = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                en[i] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                issue(i, a, m, d, 1'b0);
                wait_ready(i, 1'b1, 1'b0);
            end else begin
                issue(i, a, m, d, 1'b1);
                wait_ready(i, 1'b1, 1'b1);
            end
        end
        en[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; addr[i] = 32'h0; mask[i] = 4'h0; wdata[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check32("reset_ready", i, {31'b0, ready[i]}, 32'd0);
            check32("reset_err", i, {31'b0, err[i]}, 32'd0);
            check32("reset_rdata", i, rdata[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_inst(0);
        run_inst(1);

        // Reset during WAIT: the write of 0x55 must be dropped.
        issue(1, 32'hC, 4'hF, 32'h0, 1'b0);
        wait_ready(1, 1'b0, 1'b0);
        en[1] = 1'b0;
        @(negedge clk);
        en[1] = 1'b1; addr[1] = 32'hC; mask[1] = 4'hF; wdata[1] = 32'h55;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("rst_wait_ready", 1, {31'b0, ready[1]}, 32'd0);
        check32("rst_wait_rdata", 1, rdata[1], 32'd0);
        en[1] = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[1] === 1'b1) pulses++;
        end
        check32("rst_wait_no_ready", 1, 32'(pulses), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(1, 32'hC, 4'h0, 32'h0, 1'b0);
        wait_ready(1, 1'b0, 1'b0);
        en[1] = 1'b0;

        // Reset in RESP: the committed write is kept, ready drops at once.
        @(negedge clk);
        issue(1, 32'h8, 4'hF, 32'hA5A50F0F, 1'b0);
        wait_ready(1, 1'b0, 1'b0);
        en[1] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check32("rst_resp_ready", 1, {31'b0, ready[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1, 32'h8, 4'h0, 32'h0, 1'b0);
        wait_ready(1, 1'b0, 1'b0);
        en[1] = 1'b0;
        repeat (3) @(negedge clk);

        check32("pending_exp", 0, 32'(exp_q0.size()), 32'd0);
        check32("pending_exp", 1, 32'(exp_q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
